// File: rtl/rect_plot_ctrl_if.sv
// Operator/pixel-sink bundle for rect_plot_ctrl: corner and colour entry on
// one side, a valid/ready pixel stream and status flags on the other.
interface rect_plot_ctrl_if;
  logic       go;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       ready;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output go, x_in, y_in, colour_in, ready,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  go, x_in, y_in, colour_in, ready,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/rect_plot_ctrl.sv
// Filled-rectangle plotter: two go presses enter opposite corners, then the
// rectangle is emitted in raster order as a valid/ready pixel stream.
module rect_plot_ctrl #(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic             clk,
  input  logic             resetn,
  rect_plot_ctrl_if.slave  bus
);

  localparam logic [7:0] XLIM = 8'(X_MAX);
  localparam logic [6:0] YLIM = 7'(Y_MAX);

  typedef enum logic [2:0] {
    LOAD_TOP = 3'd0,
    TOP_WAIT = 3'd1,
    LOAD_BOT = 3'd2,
    BOT_WAIT = 3'd3,
    DRAW     = 3'd4,
    DONE     = 3'd5
  } state_t;

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > XLIM) ? XLIM : v;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [6:0] v);
    return (v > YLIM) ? YLIM : v;
  endfunction

  state_t     state_q;
  logic [7:0] ax_q, bx_q, xmin_q, xmax_q, cx_q;
  logic [6:0] ay_q, by_q, ymin_q, ymax_q, cy_q;
  logic [2:0] col_q;
  logic       plot_q, busy_q, done_q;

  logic [7:0] xin_d, xmin_d, xmax_d;
  logic [6:0] yin_d, ymin_d, ymax_d;

  // Clamped corner inputs and the bounding box of the two stored corners.
  always_comb begin
    xin_d  = clamp_x(bus.x_in);
    yin_d  = clamp_y(bus.y_in);
    xmin_d = (ax_q < bx_q) ? ax_q : bx_q;
    xmax_d = (ax_q < bx_q) ? bx_q : ax_q;
    ymin_d = (ay_q < by_q) ? ay_q : by_q;
    ymax_d = (ay_q < by_q) ? by_q : ay_q;
  end

  // Control FSM, corner capture, raster counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= LOAD_TOP;
      ax_q    <= 8'd0;
      bx_q    <= 8'd0;
      xmin_q  <= 8'd0;
      xmax_q  <= 8'd0;
      cx_q    <= 8'd0;
      ay_q    <= 7'd0;
      by_q    <= 7'd0;
      ymin_q  <= 7'd0;
      ymax_q  <= 7'd0;
      cy_q    <= 7'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD_TOP, DONE: begin
          if (bus.go) begin
            ax_q    <= xin_d;
            ay_q    <= yin_d;
            done_q  <= 1'b0;
            state_q <= TOP_WAIT;
          end else begin
            state_q <= state_q;
          end
        end
        TOP_WAIT: begin
          if (!bus.go) state_q <= LOAD_BOT;
          else         state_q <= TOP_WAIT;
        end
        LOAD_BOT: begin
          if (bus.go) begin
            bx_q    <= xin_d;
            by_q    <= yin_d;
            col_q   <= bus.colour_in;
            state_q <= BOT_WAIT;
          end else begin
            state_q <= LOAD_BOT;
          end
        end
        BOT_WAIT: begin
          if (!bus.go) begin
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cx_q    <= xmin_d;
            cy_q    <= ymin_d;
            plot_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= DRAW;
          end else begin
            state_q <= BOT_WAIT;
          end
        end
        DRAW: begin
          // go is deliberately not looked at here; only the sink paces the fill.
          if (bus.ready) begin
            if (cx_q < xmax_q) begin
              cx_q <= cx_q + 8'd1;
            end else if (cy_q < ymax_q) begin
              cx_q <= xmin_q;
              cy_q <= cy_q + 7'd1;
            end else begin
              plot_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= DRAW;
          end
        end
        default: begin
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= LOAD_TOP;
        end
      endcase
    end
  end

  assign bus.x_out      = cx_q;
  assign bus.y_out      = cy_q;
  assign bus.colour_out = col_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_rect_plot_ctrl.sv
// Bench for rect_plot_ctrl: directed corner cases plus random fills, each
// compared pixel by pixel against a raster list built from the rectangle.
module tb_rect_plot_ctrl;

  localparam int XM = 159;
  localparam int YM = 119;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rect_plot_ctrl_if bus ();

  rect_plot_ctrl #(.X_MAX(XM), .Y_MAX(YM)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_x"},    32'(bus.x_out), 32'd0);
    check({tag, "_y"},    32'(bus.y_out), 32'd0);
    check({tag, "_col"},  32'(bus.colour_out), 32'd0);
    check({tag, "_plot"}, 32'(bus.plot), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  // mode: 0 ready held high, 1 ready alternating 1,0,..., 2 random ready.
  // abort_at >= 0 pulls resetn low once that many pixels have been taken.
  task automatic run_fill(input int ax, input int ay, input int bx, input int by,
                          input int col, input int mode, input int abort_at);
    int px[$];
    int py[$];
    int x0, x1, y0, y1, cax, cay, cbx, cby;
    int idx, cyc;
    logic rdy;
    cax = (ax > XM) ? XM : ax;
    cay = (ay > YM) ? YM : ay;
    cbx = (bx > XM) ? XM : bx;
    cby = (by > YM) ? YM : by;
    x0 = (cax < cbx) ? cax : cbx;
    x1 = (cax < cbx) ? cbx : cax;
    y0 = (cay < cby) ? cay : cby;
    y1 = (cay < cby) ? cby : cay;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        px.push_back(x);
        py.push_back(y);
      end

    bus.x_in = 8'(ax);
    bus.y_in = 7'(ay);
    bus.go   = 1'b1;
    step();
    check("top_wait_plot", 32'(bus.plot), 32'd0);
    bus.go = 1'b0;
    bus.x_in = 8'($urandom);
    step();
    bus.x_in      = 8'(bx);
    bus.y_in      = 7'(by);
    bus.colour_in = 3'(col);
    bus.go        = 1'b1;
    step();
    check("bot_wait_busy", 32'(bus.busy), 32'd0);
    bus.go        = 1'b0;
    bus.x_in      = 8'($urandom);
    bus.y_in      = 7'($urandom);
    bus.colour_in = 3'($urandom);
    step();

    idx = 0;
    cyc = 0;
    while (idx < px.size() && cyc < 4000) begin
      check("draw_plot", 32'(bus.plot), 32'd1);
      check("draw_busy", 32'(bus.busy), 32'd1);
      check("draw_done", 32'(bus.done), 32'd0);
      check("pix_x",     32'(bus.x_out), 32'(px[idx]));
      check("pix_y",     32'(bus.y_out), 32'(py[idx]));
      check("pix_col",   32'(bus.colour_out), 32'(col));
      if (abort_at >= 0 && idx == abort_at) begin
        resetn = 1'b0;
        step();
        check_idle_zero("mid_reset");
        resetn = 1'b1;
        bus.ready = 1'b0;
        bus.go = 1'b0;
        step();
        check_idle_zero("post_reset");
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      bus.ready = rdy;
      bus.go    = 1'($urandom);
      step();
      if (rdy) idx++;
      cyc++;
    end
    check("fill_count", 32'(idx), 32'(px.size()));
    if (mode == 0) check("fill_cycles", 32'(cyc), 32'(px.size()));
    bus.go = 1'b0;
    bus.ready = 1'($urandom);
    check("end_plot", 32'(bus.plot), 32'd0);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_done", 32'(bus.done), 32'd1);
    step();
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_plot", 32'(bus.plot), 32'd0);
  endtask

  initial begin
    bus.go = 1'b0;
    bus.x_in = 8'd0;
    bus.y_in = 7'd0;
    bus.colour_in = 3'd0;
    bus.ready = 1'b1;
    resetn = 1'b0;
    step();
    step();
    check_idle_zero("reset");
    resetn = 1'b1;
    step();
    check_idle_zero("idle");

    run_fill(10, 20, 12, 21, 5, 0, -1);
    run_fill(12, 21, 10, 20, 5, 0, -1);
    run_fill(0, 0, 0, 0, 3, 0, -1);
    run_fill(200, 127, 158, 118, 6, 0, -1);
    run_fill(10, 20, 12, 21, 5, 1, -1);
    run_fill(10, 20, 12, 21, 5, 0, 3);
    run_fill(10, 20, 12, 21, 5, 0, -1);
    run_fill(255, 0, 150, 3, 7, 2, -1);

    for (int n = 0; n < 20; n++) begin
      int ax, ay;
      ax = int'($urandom_range(0, 255));
      ay = int'($urandom_range(0, 127));
      run_fill(ax, ay,
               (ax + int'($urandom_range(0, 5))) % 256,
               (ay + 128 - int'($urandom_range(0, 4))) % 128,
               int'($urandom_range(0, 7)), 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_plot_ctrl.md
RECT_PLOT_CTRL -- requirements
Module: rect_plot_ctrl

Interface
REQ-001 SHALL have parameter X_MAX, default 159, largest legal x coordinate.
REQ-002 SHALL have parameter Y_MAX, default 119, largest legal y coordinate.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 go  input  1  operator strobe, active-high level, already inverted from key.
REQ-006 x_in  input  8  corner x coordinate.
REQ-007 y_in  input  7  corner y coordinate.
REQ-008 colour_in  input  3  fill colour.
REQ-009 ready  input  1  pixel sink accepts the current pixel this cycle.
REQ-010 x_out  output  8  pixel x.
REQ-011 y_out  output  7  pixel y.
REQ-012 colour_out  output  3  pixel colour.
REQ-013 plot  output  1  pixel valid (write enable).
REQ-014 busy  output  1  fill in progress.
REQ-015 done  output  1  last fill complete, idle.

Function
REQ-016 SHALL implement states LOAD_TOP, TOP_WAIT, LOAD_BOT, BOT_WAIT, DRAW, DONE.
REQ-017 Transitions SHALL be:
- LOAD_TOP: go=1 -> TOP_WAIT, else stay.
- TOP_WAIT: go=0 -> LOAD_BOT, else stay.
- LOAD_BOT: go=1 -> BOT_WAIT, else stay.
- BOT_WAIT: go=0 -> DRAW, else stay.
- DRAW: last pixel accepted -> DONE, else stay.
- DONE: go=1 -> TOP_WAIT, else stay.
- Illegal encodings -> LOAD_TOP.
REQ-018 Corner A SHALL be captured from x_in/y_in on the edge leaving LOAD_TOP or DONE with go=1.
REQ-019 Corner B and colour_in SHALL be captured on the edge leaving LOAD_BOT with go=1.
REQ-020 Captured coordinates SHALL be clamped: x > X_MAX -> X_MAX; y > Y_MAX -> Y_MAX.
REQ-021 On the BOT_WAIT->DRAW edge, xmin/xmax and ymin/ymax SHALL be the per-axis min/max of A and B; corner order is irrelevant.
REQ-022 On the same edge, cx SHALL load xmin and cy SHALL load ymin.
REQ-023 plot SHALL be 1 exactly when in DRAW; first plot is the cycle after BOT_WAIT sees go=0.
REQ-024 x_out=cx, y_out=cy, colour_out = captured colour; all registered, no combinational input-to-output path.
REQ-025 Handshake: a pixel is transferred when plot=1 and ready=1.
REQ-026 With ready=0, cx, cy, and outputs SHALL hold.
REQ-027 Raster order on each transfer:
- cx<xmax: cx+1.
- cx=xmax, cy<ymax: cx=xmin, cy+1.
- cx=xmax, cy=ymax: go to DONE.
REQ-028 Exactly (xmax-xmin+1)*(ymax-ymin+1) transfers per fill; a degenerate rectangle (A=B) yields 1 transfer.
REQ-029 With ready held 1, fill SHALL take exactly N consecutive plot cycles.
REQ-030 go SHALL be ignored during DRAW.
REQ-031 busy=1 in DRAW only; done=1 in DONE only.
REQ-032 Counters SHALL never exceed X_MAX/Y_MAX and SHALL not overflow their widths.

Reset
REQ-033 resetn=0 at a rising edge SHALL force LOAD_TOP regardless of state, including mid-DRAW.
REQ-034 Reset SHALL clear all coordinate, colour, and counter registers to 0; plot, busy, done = 0.
REQ-035 Outputs SHALL be 0 the cycle after reset; the pending pixel is dropped and the fill is not resumed.

Verification
REQ-036 A=(10,20), B=(12,21), colour 5, ready=1 -> 6 plots: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour_out=5, then done=1.
REQ-037 A=(12,21), B=(10,20) -> identical 6-pixel sequence as REQ-036.
REQ-038 A=B=(0,0), ready=1 -> single plot at (0,0), DONE next cycle.
REQ-039 A=(200,127), B=(158,118) -> 4 plots: (158,118),(159,118),(158,119),(159,119).
REQ-040 REQ-036 with ready toggling 1,0,1,0 -> same 6 pixels, each held while ready=0; go pulses in DRAW ignored.
REQ-041 resetn=0 after 3rd transfer of REQ-036 -> plot=0 next cycle, state LOAD_TOP, registers 0; new go sequence fills normally.
